fft_in_frame_loader: RTL and testbench
======================================

Name: fft_in_frame_loader

Overview:
Streaming front-end feeding the parallel-4 FFT input interface (fftIn0_up/fftIn0_down/fftIn1_up/fftIn1_down). It accepts one complex sample per clock with a valid/ready handshake and buffers complete N-point frames in a ping-pong memory. It replays each frame as N/4 cycles of four lanes in the order the first butterfly stage requires, with an enable strobe that drives the FFT enable chain.

Parameters:
NBITS, 10, bits per real/imag component; sample word is {re,im}, 2*NBITS wide, two's complement.
N, 128, frame length in points; power of two, N >= 8.
LOGN, $clog2(N), localparam, address width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
i_data  in  2*NBITS  input sample {re[2*NBITS-1:NBITS], im[NBITS-1:0]}.
i_valid  in  1  i_data valid this cycle.
o_ready  out  1  loader can accept i_data this cycle; a sample transfers when i_valid && o_ready.
fftIn0_up  out  2*NBITS  lane x[k].
fftIn0_down  out  2*NBITS  lane x[k+N/2].
fftIn1_up  out  2*NBITS  lane x[k+N/4].
fftIn1_down  out  2*NBITS  lane x[k+3N/4].
o_enable  out  1  the four lanes are valid this cycle; drives the FFT in_enable chain.
o_frame_start  out  1  high with o_enable on the first output cycle (k=0) of each frame only.

Behaviour:
- Reset (async, any time): all four lane outputs = 0, o_enable = 0, o_frame_start = 0, o_ready = 0. Both banks are marked empty, write and read pointers = 0, and the reader FSM = IDLE. o_ready rises on the first clock edge after rst deasserts. A frame that is partially written or partially read at reset is discarded and never emitted.
- Memory: two banks (A, B). Each bank is four sub-RAMs of N/4 words. The write address bits [LOGN-1:LOGN-2] select the sub-RAM: 0 -> lane0_up, 1 -> lane1_up, 2 -> lane0_down, 3 -> lane1_down. Reads are synchronous with one-cycle latency.
- Writer: writes the accepted sample at wr_addr into the current write bank, then increments wr_addr. When wr_addr = N-1 is accepted, the bank's full flag is set, wr_addr wraps to 0 and the writer toggles bank. Writing starts in bank A after reset.
- o_ready is registered and equals NOT(full flag of the current write bank). It drops only if the writer reaches a bank still owned by the reader. i_valid gaps simply pause wr_addr. Data is never overwritten or dropped.
- Reader FSM:
  - IDLE: if the next read bank is full, go to READ at the next edge with rd_addr = 0.
  - READ: issues rd_addr = 0..N/4-1, one per cycle, and reads all four sub-RAMs of the bank at the same address.
  - After issuing N/4-1: clear that bank's full flag on the same edge and toggle the read bank. If the other bank is already full, stay in READ with rd_addr = 0 (no gap). Otherwise go to IDLE.
  - A full flag that is set and cleared on the same edge cannot occur, because the banks differ.
- Latency: if the last sample of a frame is accepted at edge E, o_enable and o_frame_start are high in the cycle after edge E+2 (address issued at E+1, data registered at E+2). o_enable then stays high for exactly N/4 consecutive cycles.
- Lane values are registered and pass through bit-exact (no scaling, rounding or sign change). Lanes are 0 whenever o_enable = 0.
- There is no output backpressure; the FFT consumes every o_enable cycle.
- Throughput: the reader needs N/4 cycles per frame and the writer needs at least N, so o_ready stays high under continuous input. It is a guard only.
- A single beat that both completes a frame and finds the other bank empty behaves normally; there are no simultaneous-event conflicts beyond those stated above.

Test Plan:
- Single frame, N=128, sample k = {re=k, im=-k}, continuous i_valid -> 32 o_enable cycles. Cycle 0: lanes (0,64,32,96) with o_frame_start=1. Cycle 31: lanes (31,95,63,127). First enable exactly 2 edges after the last accept.
- Three back-to-back frames with continuous input -> o_ready never drops. Each frame emits 32 enable cycles with one o_frame_start. Frame contents map to the correct frames with no bank crossover.
- Random i_valid duty of about 30% -> output identical to the continuous case, apart from timing. Each frame's first o_enable is 2 edges after its 128th accept.
- Extreme values: re = -2^(NBITS-1), im = 2^(NBITS-1)-1 (-512/511) in every position -> appear unchanged on all lanes.
- Async rst asserted mid-write (after 70 samples) and, separately, mid-read (k=10) -> outputs are 0 immediately and o_ready is 0 during reset. The next full frame emits correctly, and no stale data appears.
- Idle between frames -> lanes stay 0 and o_enable stays 0 while no bank is full.

Source files
------------

// File: rtl/fft_in_frame_loader.sv
// fft_in_frame_loader
// Streaming front-end for a parallel-4 FFT. Accepts one complex sample per
// clock, buffers whole N-point frames in a ping-pong memory, and replays each
// frame as N/4 beats of four lanes (x[k], x[k+N/2], x[k+N/4], x[k+3N/4]).
module fft_in_frame_loader #(
    parameter int NBITS = 10,
    parameter int N     = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*NBITS-1:0]   i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [2*NBITS-1:0]   fftIn0_up,
    output logic [2*NBITS-1:0]   fftIn0_down,
    output logic [2*NBITS-1:0]   fftIn1_up,
    output logic [2*NBITS-1:0]   fftIn1_down,
    output logic                 o_enable,
    output logic                 o_frame_start
);

    localparam int LOGN = $clog2(N);
    localparam int W    = 2 * NBITS;
    localparam int Q    = N / 4;
    localparam int QB   = LOGN - 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    // Writer state
    logic            r_wr_bank;
    logic [LOGN-1:0] r_wr_addr;
    logic [1:0]      r_full;
    logic            r_ready;

    // Reader state
    state_t          r_state;
    state_t          w_state_next;
    logic            r_rd_bank;
    logic            w_rd_bank_next;
    logic [QB-1:0]   r_rd_addr;
    logic [QB-1:0]   w_rd_addr_next;

    // Output strobes
    logic            r_enable;
    logic            r_frame_start;

    // Internal combinational signals
    logic            w_accept;
    logic            w_wr_last;
    logic            w_issue;
    logic            w_rd_last;
    logic [1:0]      w_full_next;
    logic            w_wr_bank_next;
    logic [W-1:0]    w_lane [4];

    assign w_accept       = i_valid && r_ready;
    assign w_wr_last      = w_accept && (r_wr_addr == LOGN'(N - 1));
    assign w_issue        = (r_state == S_READ);
    assign w_rd_last      = w_issue && (r_rd_addr == QB'(Q - 1));
    assign w_wr_bank_next = r_wr_bank ^ w_wr_last;

    // Full flags: the writer sets its bank on the last sample, the reader
    // clears its bank after the last address; the two banks always differ.
    always_comb begin
        w_full_next = r_full;
        if (w_wr_last) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    // Writer: address/bank advance, full flags and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
            r_full    <= 2'b00;
            r_ready   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            r_wr_bank <= w_wr_bank_next;
            r_full    <= w_full_next;
            r_ready   <= ~w_full_next[w_wr_bank_next];
        end
    end

    // Reader next-state: start on a full bank, chain straight into the other
    // bank when it is already full so back-to-back frames have no gap.
    always_comb begin
        w_state_next   = r_state;
        w_rd_addr_next = r_rd_addr;
        w_rd_bank_next = r_rd_bank;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_next   = S_READ;
                    w_rd_addr_next = '0;
                end
            end
            S_READ: begin
                if (w_rd_last) begin
                    w_rd_bank_next = ~r_rd_bank;
                    w_rd_addr_next = '0;
                    if (r_full[~r_rd_bank]) begin
                        w_state_next = S_READ;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_rd_addr_next = r_rd_addr + 1'b1;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_rd_addr_next = '0;
            end
        endcase
    end

    // Reader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rd_bank <= w_rd_bank_next;
            r_rd_addr <= w_rd_addr_next;
        end
    end

    // Output strobes, aligned with the registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_enable      <= w_issue;
            r_frame_start <= w_issue && (r_rd_addr == '0);
        end
    end

    // One sub-RAM per lane; the bank is the top address bit of each sub-RAM.
    // Sub-RAM index 0..3 = lane0_up, lane1_up, lane0_down, lane1_down.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [W-1:0] r_mem [0:2*Q-1];
            logic [W-1:0] r_q;

            // Sample write into this lane's sub-RAM.
            always_ff @(posedge clk) begin
                if (w_accept && (r_wr_addr[LOGN-1:LOGN-2] == 2'(gi))) begin
                    r_mem[{r_wr_bank, r_wr_addr[QB-1:0]}] <= i_data;
                end
            end

            // Registered read; the lane is forced to zero outside enable beats.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (w_issue) begin
                    r_q <= r_mem[{r_rd_bank, r_rd_addr}];
                end else begin
                    r_q <= '0;
                end
            end

            assign w_lane[gi] = r_q;
        end
    endgenerate

    assign o_ready       = r_ready;
    assign o_enable      = r_enable;
    assign o_frame_start = r_frame_start;
    assign fftIn0_up     = w_lane[0];
    assign fftIn1_up     = w_lane[1];
    assign fftIn0_down   = w_lane[2];
    assign fftIn1_down   = w_lane[3];

endmodule

// File: tb/tb_fft_in_frame_loader.sv
// Testbench for fft_in_frame_loader (N=128, NBITS=10).
// A negedge monitor keeps a scoreboard of accepted frames and checks every
// output beat; a vector table drives whole-frame scenarios and hand-written
// sequences cover resets and idle periods.
module tb_fft_in_frame_loader;

    localparam int NBITS = 10;
    localparam int N     = 128;
    localparam int W     = 2 * NBITS;

    logic         clk;
    logic         rst;
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down;
    logic         o_enable;
    logic         o_frame_start;

    fft_in_frame_loader #(.NBITS(NBITS), .N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .fftIn0_up     (fftIn0_up),
        .fftIn0_down   (fftIn0_down),
        .fftIn1_up     (fftIn1_up),
        .fftIn1_down   (fftIn1_down),
        .o_enable      (o_enable),
        .o_frame_start (o_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] mk(int re, int im);
        return {re[NBITS-1:0], im[NBITS-1:0]};
    endfunction

    function automatic logic [W-1:0] samp(int pat, int idx);
        case (pat)
            0:       return mk(idx, -idx);
            1:       return mk(-512, 511);
            default: return mk(idx + 100, (idx * 7) % 512 - 200);
        endcase
    endfunction

    function automatic logic [3:0][W-1:0] set4(logic [W-1:0] a, logic [W-1:0] b,
                                               logic [W-1:0] c, logic [W-1:0] d);
        logic [3:0][W-1:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int           ncyc = 0;
    logic [W-1:0] cur [N];
    int           cur_n = 0;
    logic [W-1:0] frame_q [$];
    int           lat_q [$];
    int           out_k = 0;
    int           frames_done = 0;
    logic [3:0][W-1:0] first_l, last_l;

    always @(negedge clk) begin
        logic [3:0][W-1:0] lanes;
        ncyc++;
        lanes = set4(fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down);
        if (rst) begin
            chk("rst_enable", o_enable, 0);
            chk("rst_frame_start", o_frame_start, 0);
            chk("rst_ready", o_ready, 0);
            chk("rst_lanes", lanes, 0);
            cur_n = 0;
            frame_q.delete();
            lat_q.delete();
            out_k = 0;
        end else begin
            if (i_valid && o_ready) begin
                cur[cur_n] = i_data;
                cur_n++;
                if (cur_n == N) begin
                    for (int j = 0; j < N; j++) frame_q.push_back(cur[j]);
                    lat_q.push_back(ncyc);
                    cur_n = 0;
                end
            end
            if (o_enable) begin
                if (frame_q.size() < N) begin
                    chk("enable_without_frame", frame_q.size(), N);
                end else begin
                    chk("frame_start", o_frame_start, (out_k == 0));
                    if (out_k == 0) begin
                        chk("latency", ncyc - lat_q[0], 3);
                        first_l = lanes;
                    end
                    chk("lane0_up",   fftIn0_up,   frame_q[out_k]);
                    chk("lane0_down", fftIn0_down, frame_q[out_k + 64]);
                    chk("lane1_up",   fftIn1_up,   frame_q[out_k + 32]);
                    chk("lane1_down", fftIn1_down, frame_q[out_k + 96]);
                    last_l = lanes;
                    out_k++;
                    if (out_k == N / 4) begin
                        for (int j = 0; j < N; j++) void'(frame_q.pop_front());
                        void'(lat_q.pop_front());
                        out_k = 0;
                        frames_done++;
                    end
                end
            end else begin
                chk("enable_gap", out_k, 0);
                chk("idle_frame_start", o_frame_start, 0);
                chk("idle_lanes", lanes, 0);
            end
        end
    end

    // ---------------- driver ----------------
    int ready_drops = 0;

    task automatic send_frame(int pat, int duty, int n);
        int idx = 0;
        int t = 0;
        while (idx < n && t < 5000) begin
            @(posedge clk); #1;
            t++;
            if (!o_ready) ready_drops++;
            if ($urandom_range(99) < duty) begin
                i_valid = 1'b1;
                i_data  = samp(pat, idx);
                if (o_ready) idx++;
            end else begin
                i_valid = 1'b0;
            end
        end
        if (idx < n) chk("send_timeout", idx, n);
    endtask

    task automatic end_stream();
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_frames(int target);
        int t = 0;
        while (frames_done < target && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("frames_done", frames_done, target);
    endtask

    typedef struct {
        int                pat;
        int                duty;
        int                nfr;
        logic [3:0][W-1:0] first;
        logic [3:0][W-1:0] last;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base;
        int t;

        // lane order: in0_up=x[k], in0_down=x[k+64], in1_up=x[k+32], in1_down=x[k+96]
        vecs[0] = '{0, 100, 1, set4(mk(0,0),   mk(64,-64), mk(32,-32), mk(96,-96)),
                               set4(mk(31,-31), mk(95,-95), mk(63,-63), mk(127,-127))};
        vecs[1] = '{0, 100, 3, set4(mk(0,0),   mk(64,-64), mk(32,-32), mk(96,-96)),
                               set4(mk(31,-31), mk(95,-95), mk(63,-63), mk(127,-127))};
        vecs[2] = '{0, 30, 1,  set4(mk(0,0),   mk(64,-64), mk(32,-32), mk(96,-96)),
                               set4(mk(31,-31), mk(95,-95), mk(63,-63), mk(127,-127))};
        vecs[3] = '{1, 100, 1, set4(mk(-512,511), mk(-512,511), mk(-512,511), mk(-512,511)),
                               set4(mk(-512,511), mk(-512,511), mk(-512,511), mk(-512,511))};
        vecs[4] = '{2, 50, 2,  set4(mk(100,-200), mk(164,248), mk(132,24), mk(196,-40)),
                               set4(mk(131,17),  mk(195,-47), mk(163,241), mk(227,177))};

        rst = 1'b1;
        i_valid = 1'b0;
        i_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_release", o_ready, 0);
        @(posedge clk); #1;
        chk("ready_first_edge", o_ready, 1);

        for (int v = 0; v < 5; v++) begin
            ready_drops = 0;
            base = frames_done;
            for (int f = 0; f < vecs[v].nfr; f++) send_frame(vecs[v].pat, vecs[v].duty, N);
            end_stream();
            wait_frames(base + vecs[v].nfr);
            chk($sformatf("v%0d_ready_drops", v), ready_drops, 0);
            for (int l = 0; l < 4; l++) begin
                chk($sformatf("v%0d_first_lane%0d", v, l), first_l[l], vecs[v].first[l]);
                chk($sformatf("v%0d_last_lane%0d", v, l), last_l[l], vecs[v].last[l]);
            end
            $display("vector %0d pat=%0d duty=%0d frames=%0d errors=%0d", v, vecs[v].pat,
                     vecs[v].duty, vecs[v].nfr, errors);
        end

        // Idle: nothing buffered, enable must stay low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("idle_enable", o_enable, 0);
        end
        $display("idle period errors=%0d", errors);

        // Reset mid-write after 70 samples
        base = frames_done;
        send_frame(0, 100, 70);
        @(posedge clk); #3;
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        chk("midwrite_rst_ready", o_ready, 0);
        chk("midwrite_rst_enable", o_enable, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        send_frame(2, 100, N);
        end_stream();
        wait_frames(base + 1);
        for (int l = 0; l < 4; l++)
            chk($sformatf("midwrite_first_lane%0d", l), first_l[l], vecs[4].first[l]);
        $display("reset mid-write errors=%0d", errors);

        // Reset mid-read at k=10
        base = frames_done;
        send_frame(0, 100, N);
        end_stream();
        t = 0;
        while (out_k != 10 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("midread_reach_k10", out_k, 10);
        #2;
        chk("midread_enable_before_rst", o_enable, 1);
        rst = 1'b1;
        #1;
        chk("midread_rst_enable", o_enable, 0);
        chk("midread_rst_lane0_up", fftIn0_up, 0);
        chk("midread_rst_lane1_down", fftIn1_down, 0);
        chk("midread_rst_ready", o_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        send_frame(1, 100, N);
        end_stream();
        wait_frames(base + 1);
        for (int l = 0; l < 4; l++)
            chk($sformatf("midread_first_lane%0d", l), first_l[l], vecs[3].first[l]);
        repeat (10) @(posedge clk);
        #1 chk("midread_no_extra_frames", frames_done, base + 1);
        $display("reset mid-read errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
